// File: rtl/proyecto2_pkg.sv
// Shared definitions for the proyecto2 mini-CPU: instruction layout, opcodes,
// VGA 640x480@60 timing, built-in program and 7-segment glyphs.
package proyecto2_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_AND   = 4'd3,
        OP_OR    = 4'd4,
        OP_ADDI  = 4'd5,
        OP_LDSW  = 4'd6,
        OP_LDBTN = 4'd7,
        OP_JMP   = 4'd8,
        OP_BEQ   = 4'd9
    } opcode_e;

    // Field order matches bits [31:28] op, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] imm.
    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [15:0] imm;
    } instr_t;

    localparam logic [9:0] H_VISIBLE = 10'd640;
    localparam logic [9:0] H_FP      = 10'd16;
    localparam logic [9:0] H_SYNC    = 10'd96;
    localparam logic [9:0] H_BP      = 10'd48;
    localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam logic [9:0] V_VISIBLE = 10'd480;
    localparam logic [9:0] V_FP      = 10'd10;
    localparam logic [9:0] V_SYNC    = 10'd2;
    localparam logic [9:0] V_BP      = 10'd33;
    localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    function automatic logic [31:0] builtin_rom(input logic [3:0] addr);
        case (addr)
            4'd0:    builtin_rom = {OP_LDSW,  4'd1, 4'd0, 4'd0, 16'd0};
            4'd1:    builtin_rom = {OP_LDBTN, 4'd2, 4'd0, 4'd0, 16'd0};
            4'd2:    builtin_rom = {OP_ADDI,  4'd3, 4'd3, 4'd0, 16'd1};
            4'd3:    builtin_rom = {OP_ADD,   4'd4, 4'd1, 4'd3, 16'd0};
            4'd4:    builtin_rom = {OP_JMP,   4'd0, 4'd0, 4'd0, 16'd0};
            default: builtin_rom = 32'h0000_0000;
        endcase
    endfunction

    // Segments ordered {g,f,e,d,c,b,a}; a lit segment is driven low.
    function automatic logic [6:0] hex7seg(input logic [3:0] v);
        case (v)
            4'h0: hex7seg = 7'b1000000;
            4'h1: hex7seg = 7'b1111001;
            4'h2: hex7seg = 7'b0100100;
            4'h3: hex7seg = 7'b0110000;
            4'h4: hex7seg = 7'b0011001;
            4'h5: hex7seg = 7'b0010010;
            4'h6: hex7seg = 7'b0000010;
            4'h7: hex7seg = 7'b1111000;
            4'h8: hex7seg = 7'b0000000;
            4'h9: hex7seg = 7'b0010000;
            4'hA: hex7seg = 7'b0001000;
            4'hB: hex7seg = 7'b0000011;
            4'hC: hex7seg = 7'b1000110;
            4'hD: hex7seg = 7'b0100001;
            4'hE: hex7seg = 7'b0000110;
            default: hex7seg = 7'b0001110;
        endcase
    endfunction

endpackage

// File: rtl/proyecto2_vga_timing.sv
// 640x480@60 raster generator: derives the 25 MHz pixel clock from CLOCK_50 and
// produces sync, blanking and the current pixel coordinates.
module vga_timing
    import proyecto2_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic       vga_clk,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic [9:0] x,
    output logic [9:0] y
);

    logic       vga_clk_q;
    logic [9:0] hcnt;
    logic [9:0] vcnt;

    // Counters step on the same edge that raises VGA_CLK, i.e. while vga_clk_q is still 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_clk_q <= 1'b0;
            hcnt      <= '0;
            vcnt      <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop reading its pre-edge value.
            vga_clk_q <= ~vga_clk_q;
            if (!vga_clk_q) begin
                if (hcnt == H_TOTAL - 10'd1) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == V_TOTAL - 10'd1) ? '0 : vcnt + 10'd1;
                end else begin
                    hcnt <= hcnt + 10'd1;
                end
            end
        end
    end

    assign vga_clk = vga_clk_q;
    assign hsync   = !((hcnt >= H_VISIBLE + H_FP) && (hcnt < H_VISIBLE + H_FP + H_SYNC));
    assign vsync   = !((vcnt >= V_VISIBLE + V_FP) && (vcnt < V_VISIBLE + V_FP + V_SYNC));
    assign blank_n = (hcnt < H_VISIBLE) && (vcnt < V_VISIBLE);
    assign x       = hcnt;
    assign y       = vcnt;

endmodule

// File: rtl/proyecto2.sv
// FPGA top: single-cycle 16x32-bit mini-CPU executing a 16-word ROM, with
// 7-segment/LED readout of r3/r4 and a VGA raster tinted by r3.
module proyecto2
    import proyecto2_pkg::*;
#(
    parameter string ROM_FILE = ""
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [8:0]        SW,
    input  logic [1:0]        botones1,
    input  logic [1:0]        botones2,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1,
    output logic [9:0]        LEDR,
    output logic              VGA_CLK,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic              VGA_BLANK_N,
    output logic [15:0][31:0] leds_registers,
    output logic [31:0]       instrucciones
);

    logic [3:0]        pc;
    logic [3:0]        pc_next;
    logic [15:0][31:0] regs;
    logic [8:0]        sw_q;
    logic [3:0]        btn_q;
    instr_t            ins;
    logic [31:0]       rs1_val;
    logic [31:0]       rs2_val;
    logic [31:0]       imm_ext;
    logic              wr_en;
    logic [31:0]       wr_data;

    assign instrucciones = builtin_rom(pc);

    assign ins     = instrucciones;
    assign rs1_val = regs[ins.rs1];
    assign rs2_val = regs[ins.rs2];
    assign imm_ext = {{16{ins.imm[15]}}, ins.imm};

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        wr_en   = 1'b0;
        wr_data = '0;
        pc_next = pc + 4'd1;
        case (ins.op)
            OP_ADD:   begin wr_en = 1'b1; wr_data = rs1_val + rs2_val; end
            OP_SUB:   begin wr_en = 1'b1; wr_data = rs1_val - rs2_val; end
            OP_AND:   begin wr_en = 1'b1; wr_data = rs1_val & rs2_val; end
            OP_OR:    begin wr_en = 1'b1; wr_data = rs1_val | rs2_val; end
            OP_ADDI:  begin wr_en = 1'b1; wr_data = rs1_val + imm_ext; end
            OP_LDSW:  begin wr_en = 1'b1; wr_data = {23'b0, sw_q}; end
            OP_LDBTN: begin wr_en = 1'b1; wr_data = {28'b0, btn_q}; end
            OP_JMP:   pc_next = ins.imm[3:0];
            OP_BEQ:   if (rs1_val == rs2_val) pc_next = ins.imm[3:0];
            default:  ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            pc    <= '0;
            sw_q  <= '0;
            btn_q <= '0;
            // NOTE: the register file is flop-based and observable, so it is cleared on reset.
            regs  <= '0;
        end else begin
            pc    <= pc_next;
            sw_q  <= SW;
            btn_q <= {botones2, botones1};
            if (wr_en) regs[ins.rd] <= wr_data;
        end
    end

    assign leds_registers = regs;
    assign HEX0           = hex7seg(regs[3][3:0]);
    assign HEX1           = hex7seg(regs[3][7:4]);
    assign LEDR           = regs[4][9:0];

    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       unused_xy;

    vga_timing u_vga (
        .clk     (CLOCK_50),
        .rst_n   (reset),
        .vga_clk (VGA_CLK),
        .hsync   (VGA_HS),
        .vsync   (VGA_VS),
        .blank_n (VGA_BLANK_N),
        .x       (pix_x),
        .y       (pix_y)
    );

    assign unused_xy = ^{pix_x[9:8], pix_y[9:8]};
    assign VGA_R     = VGA_BLANK_N ? regs[3][7:0] : 8'h00;
    assign VGA_G     = VGA_BLANK_N ? pix_x[7:0]   : 8'h00;
    assign VGA_B     = VGA_BLANK_N ? pix_y[7:0]   : 8'h00;

endmodule

// File: tb/tb_proyecto2.sv
// Self-checking bench for proyecto2: checkpoint table for the CPU program, a
// per-cycle raster model for VGA, and hand sequences for reset corner cases.
module tb_proyecto2;

    logic              CLOCK_50 = 1'b0;
    logic              reset;
    logic [8:0]        SW;
    logic [1:0]        botones1;
    logic [1:0]        botones2;
    logic [6:0]        HEX0;
    logic [6:0]        HEX1;
    logic [9:0]        LEDR;
    logic              VGA_CLK;
    logic              VGA_HS;
    logic              VGA_VS;
    logic [7:0]        VGA_R;
    logic [7:0]        VGA_G;
    logic [7:0]        VGA_B;
    logic              VGA_BLANK_N;
    logic [15:0][31:0] leds_registers;
    logic [31:0]       instrucciones;

    proyecto2 dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .SW             (SW),
        .botones1       (botones1),
        .botones2       (botones2),
        .HEX0           (HEX0),
        .HEX1           (HEX1),
        .LEDR           (LEDR),
        .VGA_CLK        (VGA_CLK),
        .VGA_HS         (VGA_HS),
        .VGA_VS         (VGA_VS),
        .VGA_R          (VGA_R),
        .VGA_G          (VGA_G),
        .VGA_B          (VGA_B),
        .VGA_BLANK_N    (VGA_BLANK_N),
        .leds_registers (leds_registers),
        .instrucciones  (instrucciones)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    localparam logic [31:0] I_LDSW = 32'h6100_0000;
    localparam logic [31:0] I_ADDI = 32'h5330_0001;

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;   // CLOCK_50 edges since reset release

    typedef struct {
        int          k;
        logic [8:0]  sw;
        logic [1:0]  b1;
        logic [1:0]  b2;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] r3;
        logic [31:0] r4;
        logic [6:0]  h0;
        logic [6:0]  h1;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, k);
        end
    endtask

    // Independent raster model: after k edges, p = (k+1)/2 pixel steps; r3 = ADDIs executed so far.
    task automatic vga_check();
        int          p;
        int          h;
        int          v;
        logic [31:0] r3m;
        logic        vis;
        logic [27:0] exp_v;
        p     = (k + 1) / 2;
        h     = p % 800;
        v     = (p / 800) % 525;
        r3m   = 32'((k + 2) / 5);
        vis   = (h < 640) && (v < 480);
        exp_v = {1'(k % 2), !(h >= 656 && h < 752), !(v >= 490 && v < 492), vis,
                 vis ? r3m[7:0] : 8'h00, vis ? 8'(h) : 8'h00, vis ? 8'(v) : 8'h00};
        check("vga", {36'b0, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B},
              {36'b0, exp_v});
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        k++;
        @(negedge CLOCK_50);
        vga_check();
    endtask

    initial begin
        vecs[0] = '{k:5,    sw:9'h000, b1:2'b01, b2:2'b00, r1:0,   r2:1,  r3:1,   r4:1,   h0:7'b1111001, h1:7'b1000000};
        vecs[1] = '{k:200,  sw:9'h000, b1:2'b01, b2:2'b00, r1:0,   r2:1,  r3:40,  r4:40,  h0:7'b0000000, h1:7'b0100100};
        vecs[2] = '{k:210,  sw:9'h1FF, b1:2'b10, b2:2'b11, r1:511, r2:14, r3:42,  r4:553, h0:7'b0001000, h1:7'b0100100};
        vecs[3] = '{k:1000, sw:9'h0AA, b1:2'b00, b2:2'b01, r1:170, r2:4,  r3:200, r4:370, h0:7'b0000000, h1:7'b1000110};
        vecs[4] = '{k:3300, sw:9'h123, b1:2'b11, b2:2'b10, r1:291, r2:11, r3:660, r4:951, h0:7'b0011001, h1:7'b0010000};

        // Reset held: everything cleared, PC at 0.
        reset    = 1'b0;
        SW       = vecs[0].sw;
        botones1 = vecs[0].b1;
        botones2 = vecs[0].b2;
        repeat (3) @(negedge CLOCK_50);
        check("reset_regs", {63'b0, |leds_registers}, 64'd0);
        check("reset_instr", {32'b0, instrucciones}, {32'b0, I_LDSW});
        check("reset_hex0", {57'b0, HEX0}, {57'b0, 7'b1000000});
        check("reset_hex1", {57'b0, HEX1}, {57'b0, 7'b1000000});
        vga_check();

        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            SW       = vecs[i].sw;
            botones1 = vecs[i].b1;
            botones2 = vecs[i].b2;
            while (k < vecs[i].k) step();
            check("r0", {32'b0, leds_registers[0]}, 64'd0);
            check("r1", {32'b0, leds_registers[1]}, {32'b0, vecs[i].r1});
            check("r2", {32'b0, leds_registers[2]}, {32'b0, vecs[i].r2});
            check("r3", {32'b0, leds_registers[3]}, {32'b0, vecs[i].r3});
            check("r4", {32'b0, leds_registers[4]}, {32'b0, vecs[i].r4});
            check("r15", {32'b0, leds_registers[15]}, 64'd0);
            check("hex0", {57'b0, HEX0}, {57'b0, vecs[i].h0});
            check("hex1", {57'b0, HEX1}, {57'b0, vecs[i].h1});
            check("ledr", {54'b0, LEDR}, {54'b0, vecs[i].r4[9:0]});
            check("pc0_instr", {32'b0, instrucciones}, {32'b0, I_LDSW});
        end

        // Stop mid-loop at PC=2, then assert reset between edges: state must clear with no clock.
        step();
        step();
        check("mid_instr", {32'b0, instrucciones}, {32'b0, I_ADDI});
        #3;
        reset = 1'b0;
        #1;
        check("async_regs", {63'b0, |leds_registers}, 64'd0);
        check("async_instr", {32'b0, instrucciones}, {32'b0, I_LDSW});
        check("async_vgaclk", {63'b0, VGA_CLK}, 64'd0);
        check("async_rgb", {40'b0, VGA_R, VGA_G, VGA_B}, 64'd0);
        check("async_hex0", {57'b0, HEX0}, {57'b0, 7'b1000000});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
